// File: rtl/mem_lsu_stage.sv
// rtl/mem_lsu_stage.sv - MEM-stage load/store unit: lane-aligned data-port requests and load extension
//
// Converts a pipeline memory op into an aligned data-port request (address,
// byte enables, lane-shifted store data), stalls the pipeline until the port
// answers, and returns load data taken from the right byte lanes, sign- or
// zero-extended according to funct3.
//
// Parameters:
//   DATA_W  data-port and register width (32 or 64); LANES = DATA_W/8
//   ADDR_W  address width
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req_valid         MEM stage holds a valid instruction
//   req_read/write    load / store (write wins if both set)
//   req_funct3        size/sign: B,H,W,D(64 only),BU,HU,WU(64 only)
//   req_addr          byte address
//   req_wdata         store data, LSB-justified
//   stall             hold upstream stages (combinational)
//   done              one-cycle pulse, access complete
//   rdata_out         extended load result, valid while done
//   misaligned        one-cycle pulse, access rejected
//   mem_read/write    data-port request strobes
//   mem_addr          lane-aligned address
//   mem_mbe           byte enables
//   mem_wdata         lane-shifted store data
//   mem_rdata         data-port read data, valid with mem_resp
//   mem_resp          data port completed the request
//
// Optional feature macro: MISALIGNED_SPLIT_EN
//   When defined, misaligned accesses are executed (split into two beats
//   when they cross a lane-word) and misaligned is tied 0.

module mem_lsu_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_W-1:0]     rdata_out,
    output logic                  misaligned,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_mbe,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp
);

    localparam int         LANES   = DATA_W / 8;
    localparam int         OFF_W   = $clog2(LANES);
    localparam logic [3:0] LANES_N = 4'(LANES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_DONE    = 2'd2
`ifdef MISALIGNED_SPLIT_EN
        ,
        S_ACCESS2 = 2'd3
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    // Registered outputs
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [LANES-1:0]      r_mem_mbe;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W-1:0]     r_rdata_out;
    logic                  r_done;
    logic                  r_misaligned;

    // Latched request attributes used when the response arrives
    logic [2:0]            r_funct3;
    logic [OFF_W-1:0]      r_off;

    // Request decode
    logic                  w_op;
    logic                  w_supported;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_stall;
    logic [OFF_W-1:0]      w_off;
    logic [3:0]            w_size;
    logic [LANES-1:0]      w_size_mask;
    logic [LANES-1:0]      w_mbe1;
    logic [DATA_W-1:0]     w_wdata1;
    logic [ADDR_W-1:0]     w_addr_aligned;
    logic [DATA_W-1:0]     w_rdata_shifted;

    // Keep the low 8<<f3[1:0] bits of v, fill the rest with the sign bit
    // (signed loads) or zeros (funct3[2]=1).
    function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] v,
                                                   input logic [2:0]        f3);
        logic [DATA_W-1:0] keep;
        logic              sgn;
        int                nbits;
        nbits = 8 << f3[1:0];
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        keep = ~({DATA_W{1'b1}} << nbits);
        sgn  = ~f3[2] & (|(v & ({{(DATA_W-1){1'b0}}, 1'b1} << (nbits - 1))));
        return (v & keep) | ({DATA_W{sgn}} & ~keep);
    endfunction

    assign w_op           = req_valid & (req_read | req_write);
    assign w_off          = req_addr[OFF_W-1:0];
    assign w_size         = 4'd1 << req_funct3[1:0];
    // Sizes wider than the port are unsupported; an unsigned load of the
    // full port width (WU on 32, DU on 64) has no meaning either.
    assign w_supported    = (w_size <= LANES_N) && !(req_funct3[2] && (w_size == LANES_N));
    assign w_size_mask    = ~({LANES{1'b1}} << w_size);
    assign w_mbe1         = w_size_mask << w_off;
    assign w_wdata1       = req_wdata << {w_off, 3'b000};
    assign w_addr_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_rdata_shifted = mem_rdata >> {r_off, 3'b000};

`ifdef MISALIGNED_SPLIT_EN
    // Second-beat request: the bytes that spill past the top lane.
    logic [OFF_W:0]        w_rem;
    logic [OFF_W:0]        w_rem_r;
    logic [LANES-1:0]      w_mbe2;
    logic [DATA_W-1:0]     w_wdata2;
    logic                  w_cross;
    logic                  r_cross;
    logic [ADDR_W-1:0]     r_addr2;
    logic [LANES-1:0]      r_mbe2;
    logic [DATA_W-1:0]     r_wdata2;
    logic [DATA_W-1:0]     r_lo;

    assign w_rem    = (OFF_W+1)'(LANES) - {1'b0, w_off};
    assign w_rem_r  = (OFF_W+1)'(LANES) - {1'b0, r_off};
    assign w_mbe2   = w_size_mask >> w_rem;
    assign w_wdata2 = req_wdata >> {w_rem, 3'b000};
    assign w_cross  = |w_mbe2;
    assign w_accept = w_op & w_supported;
    assign w_reject = 1'b0;
`else
    logic [OFF_W-1:0]      w_size_m1;
    logic                  w_aligned;

    // size==LANES truncates to 0, so its mask becomes all ones: offset must be 0.
    assign w_size_m1 = OFF_W'(w_size - 4'd1);
    assign w_aligned = (w_off & w_size_m1) == '0;
    assign w_accept  = w_op & w_supported & w_aligned;
    assign w_reject  = w_op & ~w_accept;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and stall
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_accept;
                if (w_accept) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_stall = 1'b1;
                if (mem_resp) begin
`ifdef MISALIGNED_SPLIT_EN
                    w_next = r_cross ? S_ACCESS2 : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            S_ACCESS2: begin
                w_stall = 1'b1;
                if (mem_resp) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_mbe    <= '0;
            r_mem_wdata  <= '0;
            r_rdata_out  <= '0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_funct3     <= '0;
            r_off        <= '0;
`ifdef MISALIGNED_SPLIT_EN
            r_cross      <= 1'b0;
            r_addr2      <= '0;
            r_mbe2       <= '0;
            r_wdata2     <= '0;
            r_lo         <= '0;
`endif
        end else begin
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mem_read  <= ~req_write;
                        r_mem_write <= req_write;
                        r_mem_addr  <= w_addr_aligned;
                        r_mem_mbe   <= w_mbe1;
                        r_mem_wdata <= w_wdata1;
                        r_funct3    <= req_funct3;
                        r_off       <= w_off;
`ifdef MISALIGNED_SPLIT_EN
                        r_cross     <= w_cross;
                        r_addr2     <= w_addr_aligned + ADDR_W'(LANES);
                        r_mbe2      <= w_mbe2;
                        r_wdata2    <= w_wdata2;
`endif
                    end else if (w_reject) begin
                        r_misaligned <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (mem_resp) begin
`ifdef MISALIGNED_SPLIT_EN
                        if (r_cross) begin
                            // Keep the strobe high and retarget to the next lane-word.
                            r_lo        <= w_rdata_shifted;
                            r_mem_addr  <= r_addr2;
                            r_mem_mbe   <= r_mbe2;
                            r_mem_wdata <= r_wdata2;
                        end else
`endif
                        begin
                            r_mem_read  <= 1'b0;
                            r_mem_write <= 1'b0;
                            r_done      <= 1'b1;
                            r_rdata_out <= r_mem_write ? '0 : f_extend(w_rdata_shifted, r_funct3);
                        end
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                S_ACCESS2: begin
                    if (mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_done      <= 1'b1;
                        // Low bytes came from beat 1, the rest from the bottom of beat 2.
                        r_rdata_out <= r_mem_write ? '0 :
                                       f_extend(r_lo | (mem_rdata << {w_rem_r, 3'b000}), r_funct3);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign stall      = w_stall;
    assign done       = r_done;
    assign rdata_out  = r_rdata_out;
    assign misaligned = r_misaligned;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_mbe    = r_mem_mbe;
    assign mem_wdata  = r_mem_wdata;

endmodule
